ysyx_220053_csr_seq: RTL and testbench
======================================

Name: ysyx_220053_csr_seq

Overview:
- Multi-cycle CSR and trap sequencer; owns the M-mode CSRs (mstatus, mtvec, mepc, mcause).
- Executes the decoder's CSR, ecall and mret controls over several cycles.
- Drives mtvec/mepc back to the next-address logic, plus a one-shot redirect at completion.
- Sits beside the decode stage; the core stalls while in_ready is low.

Parameters:
- XLEN, 64, data width of CSRs and operands.
- ECALL_CAUSE, 11, value written to mcause on ecall (environment call from M-mode).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  decoded instruction with Csrwen/Ecall/Mret present.
- in_ready  out  1  sequencer can accept; high only in IDLE.
- Csrwen  in  1  CSR read-modify-write instruction.
- Ecall  in  1  ecall.
- Mret  in  1  mret.
- CsrOp  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- CsrId  in  12  CSR address.
- busa  in  XLEN  rs1 value.
- zimm  in  5  rs1 field, used as the immediate for the *I ops.
- pc  in  XLEN  PC of the instruction.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- rd_data  out  XLEN  old CSR value for rd.
- rd_wen  out  1  write rd (CSR ops only).
- redirect  out  1  take redirect_pc (ecall/mret).
- redirect_pc  out  XLEN  trap target or return address.
- err  out  1  unimplemented CSR, or Ecall and Mret both set.
- mtvec  out  XLEN  current mtvec.
- mepc  out  XLEN  current mepc.

Behaviour:
- States: IDLE, READ, WRITE, TRAP, DONE. Transfers happen only on valid&ready.
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - All outputs 0 except in_ready=1.
  - mstatus=64'h0000_000A_0000_1800; mtvec=0; mepc=0; mcause=0.
  - An operation in flight is abandoned; no partial CSR write survives.
- IDLE: on accept, latch all inputs.
  - Ecall (takes priority if Mret is also set; err=1 in that case) -> TRAP.
  - Else Mret -> DONE.
  - Else Csrwen -> READ.
  - in_valid with none of the three -> DONE with err=1 and no side effects.
- READ: rd_data_q <= CSR[CsrId]; unimplemented id reads 0 and sets err. -> WRITE.
- WRITE: src = busa, or the zero-extended zimm for the *I ops.
  - new = src (RW), old|src (RS), old&~src (RC).
  - No write for RS/RC/RSI/RCI when src field is 0 (rs1 index/zimm==0). RW always writes.
  - Write masks: mtvec[1:0] and mepc[1:0] forced 0. Writes to unimplemented ids are dropped.
  - -> DONE with rd_wen=1.
- TRAP, in one edge:
  - mepc <= {pc[XLEN-1:2],2'b00}; mcause <= ECALL_CAUSE.
  - mstatus.MPIE(7) <= MIE(3); MIE <= 0; MPP(12:11) <= 2'b11.
  - -> DONE with redirect_pc = mtvec as it stands after this edge.
- Mret, applied on the IDLE->DONE edge:
  - mstatus.MIE <= MPIE; MPIE <= 1; MPP <= 2'b00.
  - redirect_pc = mepc.
- DONE:
  - out_valid=1; outputs are held stable until out_ready.
  - On handshake -> IDLE; in_ready rises the same cycle.
- Latency from accept to out_valid: CSR op 3 cycles, ecall 2, mret 1, err-only 1.
- Throughput: one op in flight. in_valid while busy is ignored; the upstream must hold it.
- mtvec/mepc outputs update the cycle after the write edge.

Optional Feature:
- Macro CSR_MCYCLE_EN.
- Defined:
  - Adds 64-bit mcycle (0xB00), reset 0, incremented every cycle and wrapping at 2^64-1.
  - A CSR write in WRITE overrides that cycle's increment.
  - Reads in READ return the pre-increment value.
- Undefined: 0xB00 is unimplemented (reads 0, err=1).

Decomposition:
- Package ysyx_220053_csr_pkg:
  - CSR addresses (MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342, MCYCLE 12'hB00).
  - CsrOp encodings; state enum; mstatus bit positions; reset constant.
- Sub-module ysyx_220053_csr_regfile:
  - CSR storage, read mux, write masks, trap/mret side updates, optional mcycle.
  - The FSM and handshake stay in the top.

Test Plan:
- CSRRW to mtvec, busa=0x8000_0103, old 0 -> after 3 cycles out_valid, rd_data=0; mtvec output reads 0x8000_0100.
- CSRRS to mstatus with zimm=0 (CSRRSI) -> rd_data=0xA_0000_1800, mstatus unchanged, rd_wen=1, err=0.
- Ecall at pc=0x8000_0040 with mtvec=0x8000_0100 -> after 2 cycles redirect=1, redirect_pc=0x8000_0100; mepc=0x8000_0040, mcause=11, MIE=0, MPP=3.
- Mret after the ecall (MPIE=1) -> after 1 cycle redirect_pc=0x8000_0040, MIE=1, MPIE=1, MPP=0.
- out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; a new in_valid is ignored until the handshake.
- rst_n low during WRITE of a CSRRW to mepc -> mepc stays 0, state IDLE, out_valid=0. Ecall+Mret together -> err=1, trap taken.

Source files
------------

// File: rtl/ysyx_220053_csr_pkg.sv
// ysyx_220053_csr_pkg: shared constants for the M-mode CSR sequencer.
// Holds CSR addresses, CsrOp (funct3) encodings, FSM states, mstatus fields.
package ysyx_220053_csr_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MCYCLE  = 12'hB00;

   localparam logic [2:0] OP_RW  = 3'b001;
   localparam logic [2:0] OP_RS  = 3'b010;
   localparam logic [2:0] OP_RC  = 3'b011;
   localparam logic [2:0] OP_RWI = 3'b101;
   localparam logic [2:0] OP_RSI = 3'b110;
   localparam logic [2:0] OP_RCI = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_TRAP,
      S_DONE
   } state_e;

   localparam int MS_MIE    = 3;
   localparam int MS_MPIE   = 7;
   localparam int MS_MPP_LO = 11;

   localparam logic [63:0] MSTATUS_RST = 64'h0000_000A_0000_1800;

endpackage

// File: rtl/ysyx_220053_csr_seq_if.sv
// ysyx_220053_csr_seq_if: decoder-side request, result and trap-vector bus.
// master = decode/core side, slave = sequencer; XLEN sets data width.
interface ysyx_220053_csr_seq_if #(
   parameter int XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic            Csrwen;
   logic            Ecall;
   logic            Mret;
   logic [2:0]      CsrOp;
   logic [11:0]     CsrId;
   logic [XLEN-1:0] busa;
   logic [4:0]      zimm;
   logic [XLEN-1:0] pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] rd_data;
   logic            rd_wen;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            err;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc;

   modport master (
      output in_valid, Csrwen, Ecall, Mret, CsrOp, CsrId,
      output busa, zimm, pc, out_ready,
      input  in_ready, out_valid, rd_data, rd_wen,
      input  redirect, redirect_pc, err, mtvec, mepc
   );

   modport slave (
      input  in_valid, Csrwen, Ecall, Mret, CsrOp, CsrId,
      input  busa, zimm, pc, out_ready,
      output in_ready, out_valid, rd_data, rd_wen,
      output redirect, redirect_pc, err, mtvec, mepc
   );
endinterface

// File: rtl/ysyx_220053_csr_regfile.sv
// ysyx_220053_csr_regfile: M-mode CSR storage, read mux, masked writes,
// trap/mret side effects. Ports: rd_id->rd_val/rd_hit, wen/wr_id/wr_data,
// trap/trap_pc, mret, mtvec/mepc out. CSR_MCYCLE_EN adds mcycle (0xB00).
module ysyx_220053_csr_regfile
   import ysyx_220053_csr_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int ECALL_CAUSE = 11
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [11:0]     rd_id,
   output logic [XLEN-1:0] rd_val,
   output logic            rd_hit,
   input  logic            wen,
   input  logic [11:0]     wr_id,
   input  logic [XLEN-1:0] wr_data,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret,
   output logic [XLEN-1:0] mtvec,
   output logic [XLEN-1:0] mepc
);

   localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

   logic [XLEN-1:0] mstatus_q;
   logic [XLEN-1:0] mtvec_q;
   logic [XLEN-1:0] mepc_q;
   logic [XLEN-1:0] mcause_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mstatus_q <= MSTATUS_RST[XLEN-1:0];
         mtvec_q   <= '0;
         mepc_q    <= '0;
         mcause_q  <= '0;
      end else if (trap) begin
         mepc_q                        <= trap_pc & ALIGN;
         mcause_q                      <= XLEN'(ECALL_CAUSE);
         mstatus_q[MS_MPIE]            <= mstatus_q[MS_MIE];
         mstatus_q[MS_MIE]             <= 1'b0;
         mstatus_q[MS_MPP_LO+1:MS_MPP_LO] <= 2'b11;
      end else if (mret) begin
         mstatus_q[MS_MIE]             <= mstatus_q[MS_MPIE];
         mstatus_q[MS_MPIE]            <= 1'b1;
         mstatus_q[MS_MPP_LO+1:MS_MPP_LO] <= 2'b00;
      end else if (wen) begin
         case (wr_id)
            CSR_MSTATUS: mstatus_q <= wr_data;
            CSR_MTVEC:   mtvec_q   <= wr_data & ALIGN;
            CSR_MEPC:    mepc_q    <= wr_data & ALIGN;
            CSR_MCAUSE:  mcause_q  <= wr_data;
            default: ;
         endcase
      end
   end

`ifdef CSR_MCYCLE_EN
   logic [63:0] mcycle_q;

   // A software write wins over the free-running increment.
   always_ff @(posedge clk) begin
      if (!rst_n)
         mcycle_q <= '0;
      else if (wen && wr_id == CSR_MCYCLE)
         mcycle_q <= 64'(wr_data);
      else
         mcycle_q <= mcycle_q + 64'd1;
   end
`endif

   always_comb begin
      rd_val = '0;
      rd_hit = 1'b1;
      case (rd_id)
         CSR_MSTATUS: rd_val = mstatus_q;
         CSR_MTVEC:   rd_val = mtvec_q;
         CSR_MEPC:    rd_val = mepc_q;
         CSR_MCAUSE:  rd_val = mcause_q;
`ifdef CSR_MCYCLE_EN
         CSR_MCYCLE:  rd_val = XLEN'(mcycle_q);
`else
         CSR_MCYCLE:  rd_hit = 1'b0;
`endif
         default:     rd_hit = 1'b0;
      endcase
   end

   assign mtvec = mtvec_q;
   assign mepc  = mepc_q;

endmodule

// File: rtl/ysyx_220053_csr_seq.sv
// ysyx_220053_csr_seq: multi-cycle CSR / ecall / mret sequencer (top).
// Ports: clk, rst_n (sync, active-low), bus (csr_seq_if slave). Macro CSR_MCYCLE_EN.
module ysyx_220053_csr_seq
   import ysyx_220053_csr_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int ECALL_CAUSE = 11
) (
   input logic                   clk,
   input logic                   rst_n,
   ysyx_220053_csr_seq_if.slave  bus
);

   state_e state_q, state_d;

   logic [2:0]      op_q;
   logic [11:0]     id_q;
   logic [XLEN-1:0] busa_q;
   logic [4:0]      zimm_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] rd_data_q;
   logic            rd_wen_q;
   logic            redirect_q;
   logic [XLEN-1:0] redirect_pc_q;
   logic            err_q;

   logic            accept;
   logic [XLEN-1:0] src;
   logic [XLEN-1:0] wdata;
   logic            wr_ok;
   logic [XLEN-1:0] rf_rd_val;
   logic            rf_rd_hit;
   logic [XLEN-1:0] rf_mtvec;
   logic [XLEN-1:0] rf_mepc;

   assign accept = bus.in_valid && (state_q == S_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (bus.Ecall)
                  state_d = S_TRAP;
               else if (bus.Mret || !bus.Csrwen)
                  state_d = S_DONE;
               else
                  state_d = S_READ;
            end
         end
         S_READ:  state_d = S_WRITE;
         S_WRITE: state_d = S_DONE;
         S_TRAP:  state_d = S_DONE;
         S_DONE:  if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Set/clear forms skip the write when the rs1 field (zimm) is x0/0.
   always_comb begin
      src   = op_q[2] ? XLEN'(zimm_q) : busa_q;
      wdata = rd_data_q;
      wr_ok = 1'b0;
      case (op_q)
         OP_RW, OP_RWI: begin
            wdata = src;
            wr_ok = 1'b1;
         end
         OP_RS, OP_RSI: begin
            wdata = rd_data_q | src;
            wr_ok = (zimm_q != 5'd0);
         end
         OP_RC, OP_RCI: begin
            wdata = rd_data_q & ~src;
            wr_ok = (zimm_q != 5'd0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q          <= '0;
         id_q          <= '0;
         busa_q        <= '0;
         zimm_q        <= '0;
         pc_q          <= '0;
         rd_data_q     <= '0;
         rd_wen_q      <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         err_q         <= 1'b0;
      end else begin
         if (accept) begin
            op_q          <= bus.CsrOp;
            id_q          <= bus.CsrId;
            busa_q        <= bus.busa;
            zimm_q        <= bus.zimm;
            pc_q          <= bus.pc;
            rd_data_q     <= '0;
            rd_wen_q      <= 1'b0;
            redirect_q    <= bus.Mret && !bus.Ecall;
            redirect_pc_q <= (bus.Mret && !bus.Ecall) ? rf_mepc : '0;
            err_q         <= (bus.Ecall && bus.Mret) ||
                             !(bus.Ecall || bus.Mret || bus.Csrwen);
         end
         if (state_q == S_READ) begin
            rd_data_q <= rf_rd_val;
            if (!rf_rd_hit) err_q <= 1'b1;
         end
         if (state_q == S_WRITE)
            rd_wen_q <= 1'b1;
         // The trap edge leaves mtvec untouched, so its current value
         // is also its post-edge value.
         if (state_q == S_TRAP) begin
            redirect_q    <= 1'b1;
            redirect_pc_q <= rf_mtvec;
         end
      end
   end

   ysyx_220053_csr_regfile #(
      .XLEN        (XLEN),
      .ECALL_CAUSE (ECALL_CAUSE)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_id   (id_q),
      .rd_val  (rf_rd_val),
      .rd_hit  (rf_rd_hit),
      .wen     ((state_q == S_WRITE) && wr_ok),
      .wr_id   (id_q),
      .wr_data (wdata),
      .trap    (state_q == S_TRAP),
      .trap_pc (pc_q),
      .mret    (accept && bus.Mret && !bus.Ecall),
      .mtvec   (rf_mtvec),
      .mepc    (rf_mepc)
   );

   assign bus.in_ready    = (state_q == S_IDLE);
   assign bus.out_valid   = (state_q == S_DONE);
   assign bus.rd_data     = rd_data_q;
   assign bus.rd_wen      = rd_wen_q;
   assign bus.redirect    = redirect_q;
   assign bus.redirect_pc = redirect_pc_q;
   assign bus.err         = err_q;
   assign bus.mtvec       = rf_mtvec;
   assign bus.mepc        = rf_mepc;

endmodule

// File: tb/tb_ysyx_220053_csr_seq.sv
// tb_ysyx_220053_csr_seq: directed + random bench for the CSR sequencer,
// checked against an architectural model of the M-mode CSRs.
module tb_ysyx_220053_csr_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ysyx_220053_csr_seq_if #(.XLEN(64)) bus ();

   ysyx_220053_csr_seq #(
      .XLEN        (64),
      .ECALL_CAUSE (11)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
   logic [63:0] e_rd, e_rpc;
   logic        e_err, e_wen, e_redir;
   int          e_lat;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mstatus = 64'h0000_000A_0000_1800;
      m_mtvec   = 64'd0;
      m_mepc    = 64'd0;
      m_mcause  = 64'd0;
   endtask

   task automatic model_step(input bit cw, input bit ec, input bit mr,
                             input logic [2:0] op, input logic [11:0] id,
                             input logic [63:0] busa, input logic [4:0] zimm,
                             input logic [63:0] pc);
      logic [63:0] old, src, nv;
      bit hit, wr;
      e_rd = 0; e_err = 0; e_wen = 0; e_redir = 0; e_rpc = 0;
      if (ec) begin
         e_lat   = 2;
         e_err   = mr;
         e_redir = 1;
         e_rpc   = m_mtvec;
         m_mepc  = pc - (pc % 4);
         m_mcause = 64'd11;
         m_mstatus[7] = m_mstatus[3];
         m_mstatus[3] = 1'b0;
         m_mstatus[12:11] = 2'd3;
      end else if (mr) begin
         e_lat   = 1;
         e_redir = 1;
         e_rpc   = m_mepc;
         m_mstatus[3] = m_mstatus[7];
         m_mstatus[7] = 1'b1;
         m_mstatus[12:11] = 2'd0;
      end else if (cw) begin
         e_lat = 3;
         e_wen = 1;
         hit = 1;
         case (id)
            12'h300: old = m_mstatus;
            12'h305: old = m_mtvec;
            12'h341: old = m_mepc;
            12'h342: old = m_mcause;
            default: begin old = 0; hit = 0; end
         endcase
         e_err = !hit;
         e_rd  = old;
         src   = (op >= 3'd5) ? {59'd0, zimm} : busa;
         nv    = old;
         wr    = 0;
         if (op == 3'd1 || op == 3'd5) begin nv = src; wr = 1; end
         if (op == 3'd2 || op == 3'd6) begin nv = old | src; wr = zimm != 0; end
         if (op == 3'd3 || op == 3'd7) begin nv = old & ~src; wr = zimm != 0; end
         if (wr) begin
            case (id)
               12'h300: m_mstatus = nv;
               12'h305: m_mtvec = nv - (nv % 4);
               12'h341: m_mepc = nv - (nv % 4);
               12'h342: m_mcause = nv;
               default: ;
            endcase
         end
      end else begin
         e_lat = 1;
         e_err = 1;
      end
   endtask

   task automatic check_outs(input string tag);
      chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({tag, " rd_data"}, bus.rd_data, e_rd);
      chk({tag, " rd_wen"}, 64'(bus.rd_wen), 64'(e_wen));
      chk({tag, " err"}, 64'(bus.err), 64'(e_err));
      chk({tag, " redirect"}, 64'(bus.redirect), 64'(e_redir));
      if (e_redir)
         chk({tag, " redirect_pc"}, bus.redirect_pc, e_rpc);
      chk({tag, " mtvec"}, bus.mtvec, m_mtvec);
      chk({tag, " mepc"}, bus.mepc, m_mepc);
   endtask

   task automatic run_op(input string tag, input bit cw, input bit ec,
                         input bit mr, input logic [2:0] op,
                         input logic [11:0] id, input logic [63:0] busa,
                         input logic [4:0] zimm, input logic [63:0] pc,
                         input int hold);
      int n;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " accept"}, 64'(bus.in_ready), 64'd1);
      bus.Csrwen = cw; bus.Ecall = ec; bus.Mret = mr;
      bus.CsrOp = op; bus.CsrId = id; bus.busa = busa;
      bus.zimm = zimm; bus.pc = pc; bus.in_valid = 1'b1;
      model_step(cw, ec, mr, op, id, busa, zimm, pc);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'(e_lat));
      check_outs(tag);
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin
            bus.Csrwen = 1; bus.Ecall = 0; bus.Mret = 0;
            bus.CsrOp = 3'b001; bus.CsrId = 12'h341;
            bus.busa = 64'hDEAD_BEEF_0000_0F00; bus.in_valid = 1'b1;
         end
         @(negedge clk);
         check_outs({tag, " hold"});
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, " ready after"}, 64'(bus.in_ready), 64'd1);
      chk({tag, " valid after"}, 64'(bus.out_valid), 64'd0);
   endtask

   logic [11:0] ids [5];
   logic [2:0]  ops [6];

   initial begin
      ids = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0};
      ops = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
      bus.in_valid = 0; bus.out_ready = 0;
      bus.Csrwen = 0; bus.Ecall = 0; bus.Mret = 0;
      bus.CsrOp = 0; bus.CsrId = 0; bus.busa = 0; bus.zimm = 0; bus.pc = 0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst rd_data", bus.rd_data, 64'd0);
      chk("rst rd_wen", 64'(bus.rd_wen), 64'd0);
      chk("rst redirect", 64'(bus.redirect), 64'd0);
      chk("rst redirect_pc", bus.redirect_pc, 64'd0);
      chk("rst err", 64'(bus.err), 64'd0);
      chk("rst mtvec", bus.mtvec, 64'd0);
      chk("rst mepc", bus.mepc, 64'd0);

      run_op("rw_mtvec", 1, 0, 0, 3'b001, 12'h305, 64'h8000_0103, 5'd0, 0, 0);
      chk("mtvec value", bus.mtvec, 64'h8000_0100);
      run_op("rsi_mstatus", 1, 0, 0, 3'b110, 12'h300, 0, 5'd0, 0, 0);
      chk("mstatus rd", bus.rd_data, 64'h0000_000A_0000_1800);
      run_op("set_mie", 1, 0, 0, 3'b110, 12'h300, 0, 5'd8, 0, 0);
      run_op("ecall", 0, 1, 0, 0, 0, 0, 0, 64'h8000_0040, 0);
      chk("ecall rpc", bus.redirect_pc, 64'h8000_0100);
      chk("ecall mepc", bus.mepc, 64'h8000_0040);
      run_op("rd_mcause", 1, 0, 0, 3'b010, 12'h342, 64'hFF, 5'd0, 0, 0);
      chk("mcause", bus.rd_data, 64'd11);
      run_op("rd_mst_trap", 1, 0, 0, 3'b010, 12'h300, 0, 5'd0, 0, 0);
      chk("trap MIE", 64'(bus.rd_data[3]), 64'd0);
      chk("trap MPIE", 64'(bus.rd_data[7]), 64'd1);
      chk("trap MPP", 64'(bus.rd_data[12:11]), 64'd3);
      run_op("mret", 0, 0, 1, 0, 0, 0, 0, 0, 0);
      chk("mret rpc", bus.redirect_pc, 64'h8000_0040);
      run_op("rd_mst_mret", 1, 0, 0, 3'b010, 12'h300, 0, 5'd0, 0, 0);
      chk("mret MIE", 64'(bus.rd_data[3]), 64'd1);
      chk("mret MPP", 64'(bus.rd_data[12:11]), 64'd0);

      run_op("hold5", 1, 0, 0, 3'b001, 12'h342, 64'h55, 5'd3, 0, 5);
      run_op("both", 0, 1, 1, 0, 0, 0, 0, 64'h8000_0207, 0);
      run_op("none", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_op("unimpl", 1, 0, 0, 3'b001, 12'h7C0, 64'h1234, 5'd1, 0, 0);
`ifndef CSR_MCYCLE_EN
      run_op("mcycle_off", 1, 0, 0, 3'b010, 12'hB00, 0, 5'd0, 0, 0);
`endif

      // Reset while the CSRRW sits in its write state.
      bus.Csrwen = 1; bus.Ecall = 0; bus.Mret = 0;
      bus.CsrOp = 3'b001; bus.CsrId = 12'h341;
      bus.busa = 64'h1234_5678; bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      chk("rstw mepc", bus.mepc, 64'd0);
      chk("rstw in_ready", 64'(bus.in_ready), 64'd1);
      chk("rstw out_valid", 64'(bus.out_valid), 64'd0);
      chk("rstw mtvec", bus.mtvec, 64'd0);
      run_op("rstw rd_mepc", 1, 0, 0, 3'b010, 12'h341, 0, 5'd0, 0, 0);

      for (int k = 0; k < 40; k++) begin
         int r;
         logic [4:0] z;
         r = $urandom_range(0, 9);
         z = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         if (r == 0)
            run_op("rnd_ecall", 0, 1, 0, 0, 0, 0, 0,
                   {$urandom, $urandom}, 0);
         else if (r == 1)
            run_op("rnd_mret", 0, 0, 1, 0, 0, 0, 0, 0, 0);
         else if (r == 2)
            run_op("rnd_none", 0, 0, 0, 0, 0, 0, 0, 0, 0);
         else
            run_op("rnd_csr", 1, 0, 0, ops[$urandom_range(0, 5)],
                   ids[$urandom_range(0, 4)], {$urandom, $urandom},
                   z, 0, $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
